// File: rtl/spi_slave_pkg.sv
// Shared types and helpers for the SPI register slave.
package spi_slave_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  localparam logic CMD_WRITE = 1'b1;

  // Data is sampled on the rising SCK edge when CPOL and CPHA agree.
  function automatic logic sample_on_rise(input logic cpol, input logic cpha);
    return (cpol == cpha);
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Oversampling synchronisers for the SPI pins plus mode-aware edge strobes.
module spi_edge_sync
  import spi_slave_pkg::*;
#(
  parameter bit CPOL = 1'b0,
  parameter bit CPHA = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic sck_i,
  input  logic ssel_i,
  input  logic mosi_i,
  output logic sample_o,
  output logic shift_o,
  output logic ssel_fall_o,
  output logic ssel_rise_o,
  output logic ssel_oe_o,
  output logic mosi_o
);

  localparam bit SAMPLE_RISE = sample_on_rise(CPOL, CPHA);

  logic [2:0] sck_q;
  logic [2:0] ssel_q;
  logic [1:0] mosi_q;
  logic       seen_q;
  logic       sck_rise_s;
  logic       sck_fall_s;

  // SSEL resets to "active" so a frame open across reset cannot fake a falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_q  <= {3{CPOL}};
      ssel_q <= 3'b000;
      mosi_q <= 2'b00;
      seen_q <= 1'b0;
    end else begin
      sck_q  <= {sck_q[1:0], sck_i};
      ssel_q <= {ssel_q[1:0], ssel_i};
      mosi_q <= {mosi_q[0], mosi_i};
      seen_q <= seen_q | ssel_q[0];
    end
  end

  assign sck_rise_s  = sck_q[1] & ~sck_q[2];
  assign sck_fall_s  = ~sck_q[1] & sck_q[2];
  assign sample_o    = SAMPLE_RISE ? sck_rise_s : sck_fall_s;
  assign shift_o     = SAMPLE_RISE ? sck_fall_s : sck_rise_s;
  assign ssel_fall_o = ~ssel_q[1] & ssel_q[2];
  assign ssel_rise_o = ssel_q[1] & ~ssel_q[2];
  assign ssel_oe_o   = ~ssel_q[0] & seen_q;
  assign mosi_o      = mosi_q[1];

endmodule

// File: rtl/spi_slave_regs.sv
// SPI slave with an addressed, auto-incrementing register bank and MISO read-back.
// Optional frame counter as TX word 0: define SPI_SLAVE_REGS_STATUS_EN.
module spi_slave_regs
  import spi_slave_pkg::*;
#(
  parameter int  WIDTH = 8,
  parameter int  NREG  = 4,
  parameter bit  CPOL  = 1'b0,
  parameter bit  CPHA  = 1'b0,
  localparam int AW    = $clog2(NREG)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  SCK,
  input  logic                  SSEL,
  input  logic                  MOSI,
  output logic                  MISO,
  output logic                  MISO_OE,
  output logic [NREG*WIDTH-1:0] REGS,
  output logic                  WR_STB,
  output logic [AW-1:0]         WR_ADDR
);

  localparam int BW = $clog2(WIDTH);

  logic             sample_s, shift_s, ssel_fall_s, ssel_rise_s, ssel_oe_s, mosi_s;
  state_e           state_q, state_d;
  logic [BW-1:0]    bitcnt_q;
  logic [WIDTH-1:0] rx_q, tx_q, next_q, word0_s, rx_word_s;
  logic [AW-1:0]    ptr_q, ptr_inc_s;
  logic             wr_frame_q, first_shift_q, start_s, word_done_s;
  logic             cmd_done_s, wr_done_s, rd_done_s;
  logic [WIDTH-1:0] regs_q [NREG];
  logic             wr_stb_q, oe_q;
  logic [AW-1:0]    wr_addr_q;

  spi_edge_sync #(.CPOL(CPOL), .CPHA(CPHA)) u_sync (
    .clk         (clk),
    .rst         (rst),
    .sck_i       (SCK),
    .ssel_i      (SSEL),
    .mosi_i      (MOSI),
    .sample_o    (sample_s),
    .shift_o     (shift_s),
    .ssel_fall_o (ssel_fall_s),
    .ssel_rise_o (ssel_rise_s),
    .ssel_oe_o   (ssel_oe_s),
    .mosi_o      (mosi_s)
  );

  assign rx_word_s   = {rx_q[WIDTH-2:0], mosi_s};
  assign ptr_inc_s   = ptr_q + {{(AW-1){1'b0}}, 1'b1};
  assign start_s     = ssel_fall_s & (state_q == ST_IDLE);
  assign word_done_s = sample_s & (bitcnt_q == BW'(WIDTH - 1));

`ifdef SPI_SLAVE_REGS_STATUS_EN
  logic [7:0] frame_cnt_q;
  logic [7:0] frame_cnt_d;

  assign frame_cnt_d = frame_cnt_q + 8'd1;
  assign word0_s     = WIDTH'({{WIDTH{1'b0}}, frame_cnt_d});

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= 8'd0;
    end else if (ssel_fall_s) begin
      frame_cnt_q <= frame_cnt_d;
    end
  end
`else
  assign word0_s = {WIDTH{1'b0}};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // An SSEL rise wins over a completing command word; a completing data word still commits.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = ssel_fall_s ? ST_CMD : ST_IDLE;
      ST_CMD: begin
        if (ssel_rise_s)      state_d = ST_IDLE;
        else if (word_done_s) state_d = ST_DATA;
        else                  state_d = ST_CMD;
      end
      ST_DATA: state_d = ssel_rise_s ? ST_IDLE : ST_DATA;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_done_s = 1'b0;
    wr_done_s  = 1'b0;
    rd_done_s  = 1'b0;
    case (state_q)
      ST_CMD:  cmd_done_s = word_done_s;
      ST_DATA: begin
        wr_done_s = word_done_s & wr_frame_q;
        rd_done_s = word_done_s & ~wr_frame_q;
      end
      default: cmd_done_s = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bitcnt_q      <= {BW{1'b0}};
      rx_q          <= {WIDTH{1'b0}};
      tx_q          <= {WIDTH{1'b0}};
      next_q        <= {WIDTH{1'b0}};
      ptr_q         <= {AW{1'b0}};
      wr_frame_q    <= 1'b0;
      first_shift_q <= 1'b0;
      wr_stb_q      <= 1'b0;
      wr_addr_q     <= {AW{1'b0}};
      oe_q          <= 1'b0;
      for (int k = 0; k < NREG; k++) regs_q[k] <= {WIDTH{1'b0}};
    end else begin
      oe_q     <= ssel_oe_s;
      wr_stb_q <= wr_done_s;
      if (state_q == ST_IDLE) bitcnt_q <= {BW{1'b0}};
      else if (sample_s)      bitcnt_q <= word_done_s ? {BW{1'b0}} : bitcnt_q + BW'(1);
      if (state_q != ST_IDLE && sample_s) rx_q <= rx_word_s;

      if (start_s) begin
        next_q <= {WIDTH{1'b0}};
      end else if (cmd_done_s) begin
        ptr_q      <= rx_word_s[AW-1:0];
        wr_frame_q <= (rx_word_s[WIDTH-1] == CMD_WRITE);
        next_q     <= (rx_word_s[WIDTH-1] == CMD_WRITE) ? {WIDTH{1'b0}} : regs_q[rx_word_s[AW-1:0]];
      end else if (wr_done_s) begin
        regs_q[ptr_q] <= rx_word_s;
        wr_addr_q     <= ptr_q;
        ptr_q         <= ptr_inc_s;
        next_q        <= {WIDTH{1'b0}};
      end else if (rd_done_s) begin
        ptr_q  <= ptr_inc_s;
        next_q <= regs_q[ptr_inc_s];
      end

      // With CPHA=1 the first edge of a frame only launches the already loaded MSB.
      if (start_s) begin
        tx_q          <= word0_s;
        first_shift_q <= 1'b1;
      end else if (state_q != ST_IDLE && shift_s) begin
        first_shift_q <= 1'b0;
        if (CPHA && first_shift_q)          tx_q <= tx_q;
        else if (bitcnt_q == {BW{1'b0}})   tx_q <= next_q;
        else                                tx_q <= {tx_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  for (genvar k = 0; k < NREG; k++) begin : g_regs
    assign REGS[k*WIDTH +: WIDTH] = regs_q[k];
  end

  assign MISO    = tx_q[WIDTH-1];
  assign MISO_OE = oe_q;
  assign WR_STB  = wr_stb_q;
  assign WR_ADDR = wr_addr_q;

endmodule

// File: tb/tb_spi_slave_regs.sv
// Directed bench: a mode-0 and a mode-3 instance driven by a behavioural SPI master.
module tb_spi_slave_regs;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mosi = 1'b0;
  logic        sck0 = 1'b0, ssel0 = 1'b1;
  logic        sck3 = 1'b1, ssel3 = 1'b1;
  logic        miso0, oe0, wr0, miso3, oe3, wr3;
  logic [31:0] regs0, regs3;
  logic [1:0]  waddr0, waddr3;
  int          n_checks = 0;
  int          n_errors = 0;
  int          wr_cnt0 = 0;
  logic [1:0]  wr_last0 = 2'd0;
  logic [23:0] r;
  logic [7:0]  b;
  logic        oe_mid;
  logic [7:0]  exp_status3;
  logic [7:0]  exp_status1;

  always #5 clk = ~clk;

  spi_slave_regs #(.WIDTH(8), .NREG(4), .CPOL(1'b0), .CPHA(1'b0)) dut0 (
    .clk(clk), .rst(rst), .SCK(sck0), .SSEL(ssel0), .MOSI(mosi), .MISO(miso0),
    .MISO_OE(oe0), .REGS(regs0), .WR_STB(wr0), .WR_ADDR(waddr0)
  );

  spi_slave_regs #(.WIDTH(8), .NREG(4), .CPOL(1'b1), .CPHA(1'b1)) dut3 (
    .clk(clk), .rst(rst), .SCK(sck3), .SSEL(ssel3), .MOSI(mosi), .MISO(miso3),
    .MISO_OE(oe3), .REGS(regs3), .WR_STB(wr3), .WR_ADDR(waddr3)
  );

  always @(posedge clk) begin
    if (wr0) begin
      wr_cnt0  <= wr_cnt0 + 1;
      wr_last0 <= waddr0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_ssel(input int m, input logic v);
    if (m == 0) ssel0 = v;
    else        ssel3 = v;
  endtask

  // Shifts the top nb bits of d, MSB first; MISO captured at each sample edge.
  task automatic spi_bits(input int m, input logic [7:0] d, input int nb, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nb; i--) begin
      if (m == 0) begin
        mosi = d[i]; #80;
        rx[i] = miso0; sck0 = 1'b1; #80;
        sck0 = 1'b0;
      end else begin
        sck3 = 1'b0; mosi = d[i]; #80;
        rx[i] = miso3; sck3 = 1'b1; #80;
      end
    end
  endtask

  task automatic spi_frame(input int m, input int n, input logic [23:0] d,
                           output logic [23:0] rx, output logic oe_in);
    logic [7:0] w;
    rx = 24'h0;
    set_ssel(m, 1'b0); #160;
    oe_in = (m == 0) ? oe0 : oe3;
    for (int k = 0; k < n; k++) begin
      spi_bits(m, d[23-8*k -: 8], 8, w);
      rx[23-8*k -: 8] = w;
    end
    #160; set_ssel(m, 1'b1); #200;
  endtask

  initial begin
`ifdef SPI_SLAVE_REGS_STATUS_EN
    exp_status3 = 8'h03;
    exp_status1 = 8'h01;
`else
    exp_status3 = 8'h00;
    exp_status1 = 8'h00;
`endif
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("rst_regs0", regs0, 32'h0);
    check_eq("rst_miso0", {31'd0, miso0}, 32'd0);
    check_eq("rst_oe0", {31'd0, oe0}, 32'd0);
    check_eq("rst_wrstb0", {31'd0, wr0}, 32'd0);
    check_eq("rst_waddr0", {30'd0, waddr0}, 32'd0);

    spi_frame(0, 2, 24'h82A500, r, oe_mid);
    check_eq("wr_a5_regs", regs0, 32'h00A50000);
    check_eq("wr_a5_cnt", wr_cnt0, 32'd1);
    check_eq("wr_a5_addr", {30'd0, wr_last0}, 32'd2);

    spi_frame(0, 3, 24'h831122, r, oe_mid);
    check_eq("wrap_regs", regs0, 32'h11A50022);
    check_eq("wrap_cnt", wr_cnt0, 32'd3);
    check_eq("wrap_addr", {30'd0, wr_last0}, 32'd0);

    spi_frame(0, 3, 24'h030000, r, oe_mid);
    check_eq("rd0_word1", {24'd0, r[15:8]}, 32'h11);
    check_eq("rd0_word2", {24'd0, r[7:0]}, 32'h22);
    check_eq("rd0_no_wr", wr_cnt0, 32'd3);

    spi_frame(3, 2, 24'h813C00, r, oe_mid);
    check_eq("m3_preload", regs3, 32'h00003C00);
    spi_frame(3, 2, 24'h010000, r, oe_mid);
    check_eq("m3_rd_word", {24'd0, r[15:8]}, 32'h3C);
    check_eq("m3_oe_in", {31'd0, oe_mid}, 32'd1);
    check_eq("m3_oe_out", {31'd0, oe3}, 32'd0);

    ssel0 = 1'b0; #160;
    spi_bits(0, 8'h81, 8, b);
    spi_bits(0, 8'hFF, 5, b);
    #160; ssel0 = 1'b1; #200;
    check_eq("abort_cnt", wr_cnt0, 32'd3);
    check_eq("abort_regs", regs0, 32'h11A50022);
    spi_frame(0, 2, 24'h815A00, r, oe_mid);
    check_eq("post_abort_regs", regs0, 32'h11A55A22);
    check_eq("post_abort_addr", {30'd0, wr_last0}, 32'd1);

    ssel0 = 1'b0; #160;
    spi_bits(0, 8'h80, 8, b);
    spi_bits(0, 8'hC3, 4, b);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("mid_rst_regs0", regs0, 32'h0);
    check_eq("mid_rst_regs3", regs3, 32'h0);
    check_eq("mid_rst_miso", {31'd0, miso0}, 32'd0);
    check_eq("mid_rst_oe", {31'd0, oe0}, 32'd0);
    check_eq("mid_rst_waddr", {30'd0, waddr0}, 32'd0);
    rst = 1'b0;
    spi_bits(0, 8'h3C, 4, b);
    #160; ssel0 = 1'b1; #200;
    check_eq("mid_rst_no_wr", wr_cnt0, 32'd4);
    check_eq("mid_rst_regs_after", regs0, 32'h0);
    spi_frame(0, 2, 24'h817700, r, oe_mid);
    check_eq("post_rst_regs", regs0, 32'h00007700);
    check_eq("post_rst_addr", {30'd0, wr_last0}, 32'd1);
    check_eq("post_rst_status", {24'd0, r[23:16]}, {24'd0, exp_status1});

    spi_frame(3, 2, 24'h000000, r, oe_mid);
    spi_frame(3, 2, 24'h000000, r, oe_mid);
    spi_frame(3, 2, 24'h000000, r, oe_mid);
    check_eq("status_frame3", {24'd0, r[23:16]}, {24'd0, exp_status3});

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
